// File: rtl/logic_unit_pipe.sv
// Bitwise logic unit with one registered output stage and valid/ready handshakes.
// It also produces zero and all-ones flags and a wrapping count of delivered results.
module logic_unit_pipe #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             all_ones,
  output logic [CNT_W-1:0] ops_done
);

  function automatic logic [WIDTH-1:0] logic_op(
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y,
    input logic [2:0]       sel
  );
    logic [WIDTH-1:0] r;
    case (sel)
      3'b000:  r = x & y;
      3'b001:  r = ~(x & y);
      3'b010:  r = x | y;
      3'b011:  r = ~(x | y);
      3'b100:  r = x ^ y;
      3'b101:  r = ~(x ^ y);
      3'b110:  r = ~x;
      default: r = x;
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0] res_p0;
  logic [WIDTH-1:0] res_p1;
  logic             zr_p1;
  logic             ao_p1;
  logic             vld_p1;
  logic [CNT_W-1:0] cnt_p1;
  logic             accept;
  logic             deliver;

  assign res_p0   = logic_op(a, b, op);
  assign in_ready = !vld_p1 || out_ready;
  assign accept   = in_valid && in_ready;
  assign deliver  = vld_p1 && out_ready;

  // p0 -> p1: result register; a same-cycle accept keeps the stage full
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      res_p1 <= '0;
      zr_p1  <= 1'b1;
      ao_p1  <= 1'b0;
      cnt_p1 <= '0;
    end else begin
      if (accept) begin
        res_p1 <= res_p0;
        zr_p1  <= (res_p0 == '0);
        ao_p1  <= &res_p0;
        vld_p1 <= 1'b1;
      end else if (deliver) begin
        vld_p1 <= 1'b0;
      end
      if (deliver) cnt_p1 <= cnt_p1 + CNT_W'(1);
    end
  end

  assign out_valid = vld_p1;
  assign out       = res_p1;
  assign zr        = zr_p1;
  assign all_ones  = ao_p1;
  assign ops_done  = cnt_p1;

endmodule
